// File: rtl/mspeckey_enc_iter_pkg.sv
// Shared constants, FSM state type and rotate helpers for the iterative mSPECKEY encryption engine.
package mspeckey_pkg;

  localparam int LANE_W    = 16;
  localparam int HALF_W    = 8;
  localparam int NUM_LANES = 8;
  localparam int ROT_A     = 3;
  localparam int ROT_B     = 2;
  localparam int RND_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [HALF_W-1:0] ror8(input logic [HALF_W-1:0] v, input int unsigned n);
    return (v >> n) | (v << (HALF_W - n));
  endfunction

  function automatic logic [HALF_W-1:0] rol8(input logic [HALF_W-1:0] v, input int unsigned n);
    return (v << n) | (v >> (HALF_W - n));
  endfunction

endpackage

// File: rtl/mspeckey_enc_iter_if.sv
// Block-level valid/ready bus between a plaintext source, the encryption engine and its ciphertext sink.
interface mspeckey_enc_iter_if;

  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_i;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_o;

  modport slave (
    input  in_valid,
    input  state_i,
    input  out_ready,
    output in_ready,
    output out_valid,
    output state_o
  );

  modport master (
    output in_valid,
    output state_i,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  state_o
  );

endinterface

// File: rtl/mspeckey_enc_iter_round.sv
// One forward ARX round on a single 16-bit lane; the round constant i_rc is applied only
// when MSPECKEY_RC_EN is defined.
module mspeckey_enc_round
  import mspeckey_pkg::*;
(
  input  logic [LANE_W-1:0] i_lane,
  input  logic [RND_W-1:0]  i_rc,
  output logic [LANE_W-1:0] o_lane
);

  logic [HALF_W-1:0] w_x;
  logic [HALF_W-1:0] w_y;
  logic [HALF_W-1:0] w_sum;
  logic [HALF_W-1:0] w_xn;
  logic [HALF_W-1:0] w_yn;

  assign w_x   = i_lane[LANE_W-1:HALF_W];
  assign w_y   = i_lane[HALF_W-1:0];
  assign w_sum = ror8(w_x, ROT_A) + w_y;

`ifdef MSPECKEY_RC_EN
  assign w_xn = w_sum ^ i_rc;
`else
  logic w_unused_rc;
  assign w_unused_rc = ^i_rc;
  assign w_xn        = w_sum;
`endif

  // y' mixes in the final x', so the decryptor recovers y before undoing the add
  assign w_yn   = rol8(w_y, ROT_B) ^ w_xn;
  assign o_lane = {w_xn, w_yn};

endmodule

// File: rtl/mspeckey_enc_iter.sv
// Iterative mSPECKEY encryptor: 8 parallel 16-bit lanes, one round per clock, one block in flight.
// Optional per-round constant enabled by defining MSPECKEY_RC_EN.
module mspeckey_enc_iter
  import mspeckey_pkg::*;
#(
  parameter int ROUNDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  mspeckey_enc_iter_if.slave bus
);

  if (ROUNDS < 1 || ROUNDS > 255) begin : g_bad_rounds
    $fatal(1, "mspeckey_enc_iter: ROUNDS must be in 1..255");
  end

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

  state_t                      r_fsm;
  state_t                      w_fsm_nxt;
  logic [LANE_W*NUM_LANES-1:0] r_state;
  logic [LANE_W*NUM_LANES-1:0] w_state_rnd;
  logic [LANE_W*NUM_LANES-1:0] w_state_nxt;
  logic [RND_W-1:0]            r_rnd;
  logic [RND_W-1:0]            w_rnd_nxt;
  logic [RND_W-1:0]            w_rc;
  logic                        r_in_ready;
  logic                        r_out_valid;

  assign w_rc = r_rnd + 8'd1;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mspeckey_enc_round u_round (
      .i_lane (r_state[LANE_W*g +: LANE_W]),
      .i_rc   (w_rc),
      .o_lane (w_state_rnd[LANE_W*g +: LANE_W])
    );
  end

  // Next-state, round counter and state-register update
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_rnd_nxt   = r_rnd;
    case (r_fsm)
      IDLE: begin
        if (bus.in_valid && r_in_ready) begin
          w_state_nxt = bus.state_i;
          w_rnd_nxt   = {RND_W{1'b0}};
          w_fsm_nxt   = RUN;
        end else begin
          w_fsm_nxt = IDLE;
        end
      end
      RUN: begin
        w_state_nxt = w_state_rnd;
        w_rnd_nxt   = r_rnd + 8'd1;
        if (r_rnd == LAST_RND) begin
          w_fsm_nxt = DONE;
        end else begin
          w_fsm_nxt = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_fsm_nxt = IDLE;
        end else begin
          w_fsm_nxt = DONE;
        end
      end
      default: begin
        w_fsm_nxt = IDLE;
      end
    endcase
  end

  // Handshake flags are registered from the next state so they track the FSM without glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm       <= IDLE;
      r_state     <= '0;
      r_rnd       <= {RND_W{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_state     <= w_state_nxt;
      r_rnd       <= w_rnd_nxt;
      r_in_ready  <= (w_fsm_nxt == IDLE);
      r_out_valid <= (w_fsm_nxt == DONE);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.state_o   = r_state;

endmodule

// File: tb/tb_mspeckey_enc_iter.sv
// Self-checking bench: three engines (ROUNDS=1,2,4) against an integer-arithmetic lane model.
module tb_mspeckey_enc_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  mspeckey_enc_iter_if b1 ();
  mspeckey_enc_iter_if b2 ();
  mspeckey_enc_iter_if b4 ();

  mspeckey_enc_iter #(.ROUNDS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
  mspeckey_enc_iter #(.ROUNDS(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));
  mspeckey_enc_iter #(.ROUNDS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));

  logic         iv   [3];
  logic         oreq [3];
  logic [127:0] si   [3];
  logic         ir   [3];
  logic         ov   [3];
  logic [127:0] so   [3];
  int           rnds [3] = '{1, 2, 4};

  assign b1.in_valid = iv[0];  assign b1.out_ready = oreq[0];  assign b1.state_i = si[0];
  assign b2.in_valid = iv[1];  assign b2.out_ready = oreq[1];  assign b2.state_i = si[1];
  assign b4.in_valid = iv[2];  assign b4.out_ready = oreq[2];  assign b4.state_i = si[2];
  assign ir[0] = b1.in_ready;  assign ov[0] = b1.out_valid;    assign so[0] = b1.state_o;
  assign ir[1] = b2.in_ready;  assign ov[1] = b2.out_valid;    assign so[1] = b2.state_o;
  assign ir[2] = b4.in_ready;  assign ov[2] = b4.out_valid;    assign so[2] = b4.state_o;

  function automatic logic [15:0] lane_enc(input logic [15:0] l, input int r);
    int x, y;
    x = l[15:8];
    y = l[7:0];
    x = ((((x >> 3) | (x << 5)) & 255) + y) % 256;
`ifdef MSPECKEY_RC_EN
    x = x ^ ((r + 1) % 256);
`endif
    y = (((y << 2) | (y >> 6)) & 255) ^ x;
    return {x[7:0], y[7:0]};
  endfunction

  function automatic logic [15:0] lane_dec(input logic [15:0] l, input int r);
    int xp, yp, x, y, t;
    xp = l[15:8];
    yp = l[7:0];
    t  = yp ^ xp;
    y  = ((t >> 2) | (t << 6)) & 255;
`ifdef MSPECKEY_RC_EN
    xp = xp ^ ((r + 1) % 256);
`endif
    t  = (xp - y + 256) % 256;
    x  = ((t << 3) | (t >> 5)) & 255;
    return {x[7:0], y[7:0]};
  endfunction

  function automatic logic [127:0] blk_enc(input logic [127:0] b, input int rounds);
    logic [127:0] v;
    v = b;
    for (int r = 0; r < rounds; r++)
      for (int k = 0; k < 8; k++) v[16*k +: 16] = lane_enc(v[16*k +: 16], r);
    return v;
  endfunction

  function automatic logic [127:0] blk_dec(input logic [127:0] b, input int rounds);
    logic [127:0] v;
    v = b;
    for (int r = rounds - 1; r >= 0; r--)
      for (int k = 0; k < 8; k++) v[16*k +: 16] = lane_dec(v[16*k +: 16], r);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push one block into engine d, hold out_ready low for 'stall' cycles, then drain it
  task automatic run_blk(input int d, input logic [127:0] blk, input int stall,
                         input string tag, output logic [127:0] res);
    int cyc;
    logic busy_ok;
    chk({tag, "_rdy"}, ir[d], 1'b1);
    si[d] = blk; iv[d] = 1'b1; oreq[d] = 1'b0;
    @(negedge clk);
    iv[d] = 1'b0;
    cyc = 0;
    busy_ok = 1'b1;
    while (!ov[d] && cyc < 300) begin
      if (ir[d]) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    res = so[d];
    chk({tag, "_lat"}, 128'(cyc), 128'(rnds[d]));
    chk({tag, "_busy"}, busy_ok & ~ir[d], 1'b1);
    chk({tag, "_ct"}, res, blk_enc(blk, rnds[d]));
    for (int s = 0; s < stall; s++) begin
      iv[d] = 1'($urandom_range(0, 1));
      si[d] = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk({tag, "_hold"}, {ov[d], ir[d], so[d]}, {1'b1, 1'b0, res});
    end
    iv[d] = 1'b0;
    oreq[d] = 1'b1;
    @(negedge clk);
    oreq[d] = 1'b0;
    chk({tag, "_drain"}, {ir[d], ov[d]}, 2'b10);
  endtask

  initial begin
    logic [127:0] res;
    logic [127:0] blk;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; oreq[d] = 1'b0; si[d] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_outs", {ir[2], ov[2], so[2]}, {1'b1, 1'b0, 128'd0});
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", {ir[0], ov[0], so[0]}, {1'b1, 1'b0, 128'd0});

    run_blk(0, {8{16'h0100}}, 0, "r1_0100", res);
`ifdef MSPECKEY_RC_EN
    chk("r1_0100_const", res, {8{16'h2121}});
`else
    chk("r1_0100_const", res, {8{16'h2020}});
`endif
    run_blk(0, {8{16'h0001}}, 0, "r1_0001", res);
`ifndef MSPECKEY_RC_EN
    chk("r1_0001_const", res, {8{16'h0105}});
`endif
    run_blk(0, 128'd0, 0, "r1_zero", res);
`ifdef MSPECKEY_RC_EN
    chk("r1_zero_const", res, {8{16'h0101}});
`else
    chk("r1_zero_const", res, 128'd0);
`endif
    run_blk(0, 128'h0001_0100_FFFF_8000_00FF_1234_ABCD_7F80, 1, "r1_mix", res);

    run_blk(1, {8{16'h0100}}, 0, "r2_0100", res);
`ifdef MSPECKEY_RC_EN
    chk("r2_0100_const", res, {8{16'h47C3}});
`else
    chk("r2_0100_const", res, {8{16'h24A4}});
`endif

    run_blk(2, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE, 10, "r4_stall", res);

    // Reset during the second RUN cycle must clear everything without a clock edge
    si[2] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    iv[2] = 1'b1;
    @(negedge clk);
    iv[2] = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", {ir[2], ov[2]}, 2'b00);
    rst = 1'b1;
    #1;
    chk("async_rst", {ir[2], ov[2], so[2]}, {1'b1, 1'b0, 128'd0});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_blk(2, 128'h0F0F_F0F0_1357_9BDF_2468_ACE0_5A5A_A5A5, 0, "post_rst", res);

    for (int i = 0; i < 1000; i++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      run_blk(2, blk, $urandom_range(0, 3), "rand", res);
      chk("rand_roundtrip", blk_dec(res, 4), blk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
